// File: rtl/tcm_sram_ctrl.sv
// tcm_sram_ctrl: single-port TCM SRAM shared by core (C) and loader (L)
// requesters, round-robin arbitrated, with a stallable response pipeline.
module tcm_sram_ctrl #(
  parameter int AW     = 12,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            c_req_valid,
  output logic            c_req_ready,
  input  logic            c_req_we,
  input  logic [AW-1:0]   c_req_addr,
  input  logic [DW-1:0]   c_req_wdata,
  input  logic [DW/8-1:0] c_req_wem,
  output logic            c_rsp_valid,
  input  logic            c_rsp_ready,
  output logic [DW-1:0]   c_rsp_rdata,
  input  logic            l_req_valid,
  output logic            l_req_ready,
  input  logic            l_req_we,
  input  logic [AW-1:0]   l_req_addr,
  input  logic [DW-1:0]   l_req_wdata,
  input  logic [DW/8-1:0] l_req_wem,
  output logic            l_rsp_valid,
  input  logic            l_rsp_ready,
  output logic [DW-1:0]   l_rsp_rdata
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic            last_l;
  logic            grant_c;
  logic            grant_l;
  logic            stall;
  logic            acc;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [NB-1:0]   sel_wem;

  logic            s0_v;
  logic            s0_p;
  logic            s0_we;
  logic [DW-1:0]   rd_q;
  logic [DW-1:0]   s0_d;

  logic            fin_v;
  logic            fin_p;
  logic [DW-1:0]   fin_d;
  logic            fin_ready;

  logic [DW-1:0]   mem [DEPTH];

  // last_l set means L was served last, so C wins a tie
  always_comb begin
    grant_c = c_req_valid & (~l_req_valid | last_l);
    grant_l = l_req_valid & ~grant_c;
  end

  always_comb begin
    fin_ready = fin_p ? l_rsp_ready : c_rsp_ready;
    stall     = fin_v & ~fin_ready;
  end

  always_comb begin
    c_req_ready = grant_c & ~stall & rst_n;
    l_req_ready = grant_l & ~stall & rst_n;
    acc         = c_req_ready | l_req_ready;
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wem   = '0;
    unique case (1'b1)
      grant_c: begin
        sel_we    = c_req_we;
        sel_addr  = c_req_addr;
        sel_wdata = c_req_wdata;
        sel_wem   = c_req_wem;
      end
      grant_l: begin
        sel_we    = l_req_we;
        sel_addr  = l_req_addr;
        sel_wdata = l_req_wdata;
        sel_wem   = l_req_wem;
      end
      default: ;
    endcase
  end

  // Array and read register carry no reset; rd_q only moves on a read accept
  always_ff @(posedge clk) begin
    if (acc & sel_we) begin
      for (int i = 0; i < NB; i++) begin
        if (sel_wem[i]) begin
          mem[sel_addr][8*i +: 8] <= sel_wdata[8*i +: 8];
        end
      end
    end
    if (acc & ~sel_we) begin
      rd_q <= mem[sel_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_v   <= 1'b0;
      s0_p   <= 1'b0;
      s0_we  <= 1'b0;
      last_l <= 1'b1;
    end else if (!stall) begin
      s0_v  <= acc;
      s0_p  <= grant_l;
      s0_we <= sel_we;
      if (acc) begin
        last_l <= grant_l;
      end
    end
  end

  assign s0_d = s0_we ? '0 : rd_q;

  if (RD_LAT == 1) begin : g_lat1
    assign fin_v = s0_v;
    assign fin_p = s0_p;
    assign fin_d = s0_d;
  end else begin : g_lat2
    logic          s1_v;
    logic          s1_p;
    logic [DW-1:0] s1_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_v <= 1'b0;
        s1_p <= 1'b0;
        s1_d <= '0;
      end else if (!stall) begin
        s1_v <= s0_v;
        s1_p <= s0_p;
        s1_d <= s0_d;
      end
    end

    assign fin_v = s1_v;
    assign fin_p = s1_p;
    assign fin_d = s1_d;
  end

  always_comb begin
    c_rsp_valid = fin_v & ~fin_p;
    l_rsp_valid = fin_v & fin_p;
    c_rsp_rdata = c_rsp_valid ? fin_d : '0;
    l_rsp_rdata = l_rsp_valid ? fin_d : '0;
  end

endmodule

// File: doc/tcm_sram_ctrl.md
Name: tcm_sram_ctrl

Overview:
- Parametrised tightly-coupled-memory controller; successor to the fixed ITCM/DTCM SRAM pair on the CPU top.
- Holds one single-ported word-addressed SRAM array shared by two requesters: port C (core fetch/LSU) and port L (loader/debug).
- Provides per-port valid/ready request and response handshakes, round-robin arbitration, byte-masked writes, configurable read latency and response back-pressure.
- The ITCM and DTCM are each one instance.

Parameters:
- AW, 12, word address width; depth = 2**AW words.
- DW, 32, data width; must be a multiple of 8.
- RD_LAT, 1, request-accept to response-valid latency in cycles; legal values 1 or 2.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- c_req_valid  input  1  port C request valid.
- c_req_ready  output  1  port C request accepted this cycle when high with c_req_valid.
- c_req_we  input  1  1 = write, 0 = read.
- c_req_addr  input  AW  word address.
- c_req_wdata  input  DW  write data.
- c_req_wem  input  DW/8  byte write mask; bit i enables byte i.
- c_rsp_valid  output  1  response valid.
- c_rsp_ready  input  1  response consumed when high with c_rsp_valid.
- c_rsp_rdata  output  DW  read data; 0 for write responses.
- l_req_valid, l_req_ready, l_req_we, l_req_addr, l_req_wdata, l_req_wem, l_rsp_valid, l_rsp_ready, l_rsp_rdata: same as port C, for port L.

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low; there is one clock.

Reset values:
- c_rsp_valid = l_rsp_valid = 0; rsp_rdata = 0.
- All pipeline valid bits = 0.
- Round-robin pointer last = L, so C wins the first conflict.
- Array contents are not reset.

Arbitration:
- At most one access per cycle.
- Only one port valid: that port is granted.
- Both ports valid: the port other than `last` is granted; `last` updates on every grant.
- x_req_ready = grant_x & ~stall. Ready is combinational from valid; no request is accepted during reset.

Access:
- Write: byte i of mem[addr] is updated iff wem[i] in the accept cycle.
- Write with wem = 0 still completes and produces a response.
- Read: data is read at accept. A read accepted the cycle after a write to the same address returns the new data.

Pipeline:
- RD_LAT stages. Each stage holds valid, port id, we and data.
- An access accepted in cycle t gives x_rsp_valid high in cycle t+RD_LAT.
- Every accepted request (read or write) yields exactly one response, in order, on its own port.
- Throughput is one access per cycle when not stalled.

Back-pressure:
- stall = final stage valid & ~rsp_ready of its port.
- While stalled, all stages freeze and both req_ready are 0.
- rsp_valid and rsp_rdata hold stable until the handshake.
- With RD_LAT = 2 and both stages full, no data is lost. The memory is not re-read.

Other rules:
- rsp_valid of the port not owning the final stage is 0.
- Reset mid-operation: in-flight accesses are dropped with no response. A write accepted before reset assertion has already updated the array.
- Address wrap: addr is exactly AW bits; there is no out-of-range case.

Test Plan:
- RD_LAT=1, AW=12. Port C writes 0xDEADBEEF to addr 0x010 with wem=0xF, then reads addr 0x010 -> write response 1 cycle after accept with rdata=0. Read response 1 cycle after its accept with rdata=0xDEADBEEF.
- Byte mask: write 0x11223344 to addr 0x020, then write 0xAABBCCDD with wem=0x5, then read addr 0x020 -> rdata=0x11BB33DD.
- Conflict: both ports issue reads continuously for 6 cycles -> grants alternate C,L,C,L,C,L starting with C. Each response returns on the issuing port.
- Back-pressure, RD_LAT=2: C issues 4 back-to-back reads of addrs 0..3 (preloaded 0xA0..0xA3); c_rsp_ready held 0 for 3 cycles after the first rsp_valid -> c_req_ready=0 during the stall, first response held stable at 0xA0. All four responses 0xA0..0xA3 are delivered in order with none lost.
- Reset mid-operation: assert rst_n=0 one cycle after a read is accepted -> rsp_valid goes 0 immediately and no response appears after release. A write accepted before reset is readable afterwards.
- Throughput: L streams 16 writes then 16 reads of addrs 0x0F0..0x0FF, with rsp_ready held 1 -> 32 consecutive accepts, 32 responses, all read data correct.
